// File: rtl/ai_pkg.sv
// rtl/ai_pkg.sv - shared opcodes, state encoding and constants for the AI execute unit
package ai_pkg;

   localparam int LANES = 4;

   localparam logic [2:0] AI_MAC     = 3'b000;
   localparam logic [2:0] AI_DOT     = 3'b001;
   localparam logic [2:0] AI_ACC_WR  = 3'b010;
   localparam logic [2:0] AI_ACC_RD  = 3'b011;
   localparam logic [2:0] AI_ACC_CLR = 3'b100;
   localparam logic [2:0] AI_QNT     = 3'b101;

   localparam logic signed [31:0] INT8_MIN = -32'sd128;
   localparam logic signed [31:0] INT8_MAX = 32'sd127;

   typedef enum logic {
      AI_IDLE,
      AI_BUSY
   } ai_state_e;

endpackage

// File: rtl/ai_ex_unit_if.sv
// rtl/ai_ex_unit_if.sv - ID/EX operand bundle and EX/MEM writeback bundle of ai_ex_unit
interface ai_ex_unit_if;

   logic        flush;
   logic        in_valid;
   logic [2:0]  ai_opcode;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imm;
   logic [4:0]  rd;

   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        regwrite_out;
   logic        illegal;

   modport master (
      output flush, in_valid, ai_opcode, rs1_data, rs2_data, imm, rd,
      input  stall, busy, done, result, rd_out, regwrite_out, illegal
   );

   modport slave (
      input  flush, in_valid, ai_opcode, rs1_data, rs2_data, imm, rd,
      output stall, busy, done, result, rd_out, regwrite_out, illegal
   );

endinterface

// File: rtl/ai_lane_mac.sv
// rtl/ai_lane_mac.sv - one int8 lane product added to the partial dot sum, plus the acc update
// Define AI_SATURATE_EN to clamp the acc update to the signed 32-bit range.
module ai_lane_mac (
   input  logic [7:0]  a_i,
   input  logic [7:0]  b_i,
   input  logic [31:0] part_i,
   input  logic [31:0] acc_i,
   output logic [31:0] dot_o,
   output logic [31:0] acc_o
);

   logic signed [15:0] prod;

`ifdef AI_SATURATE_EN
   logic [32:0] wide;

   always_comb begin
      prod  = $signed(a_i) * $signed(b_i);
      dot_o = part_i + {{16{prod[15]}}, prod};
      wide  = {acc_i[31], acc_i} + {dot_o[31], dot_o};
      // Sign bits disagree only when the 32-bit sum overflowed.
      if (wide[32] != wide[31]) begin
         acc_o = wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         acc_o = wide[31:0];
      end
   end
`else
   always_comb begin
      prod  = $signed(a_i) * $signed(b_i);
      dot_o = part_i + {{16{prod[15]}}, prod};
      acc_o = acc_i + dot_o;
   end
`endif

endmodule

// File: rtl/ai_ex_unit.sv
// rtl/ai_ex_unit.sv - AI-extension execute stage: accumulator ops and 4-cycle int8 dot product
// Optional macro AI_SATURATE_EN selects saturating accumulation (see ai_lane_mac).
module ai_ex_unit
   import ai_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   ai_ex_unit_if.slave bus
);

   localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

   ai_state_e   state_q;
   logic [1:0]  lane_cnt_q;
   logic [2:0]  op_q;
   logic [31:0] rs1_q, rs2_q, work_q, acc_q;
   logic [4:0]  rd_q;
   logic        done_q, regwrite_q, illegal_q;
   logic [31:0] result_q;
   logic [4:0]  rd_out_q;

   logic               is_dot_op, accept;
   logic [31:0]        lane_dot, lane_acc, qnt_val;
   logic signed [31:0] qnt_shift;

   assign is_dot_op = (bus.ai_opcode == AI_MAC) || (bus.ai_opcode == AI_DOT);
   assign accept    = (state_q == AI_IDLE) && bus.in_valid && !bus.flush;

   ai_lane_mac u_lane_mac (
      .a_i    (rs1_q[{lane_cnt_q, 3'b000} +: 8]),
      .b_i    (rs2_q[{lane_cnt_q, 3'b000} +: 8]),
      .part_i (work_q),
      .acc_i  (acc_q),
      .dot_o  (lane_dot),
      .acc_o  (lane_acc)
   );

   always_comb begin
      qnt_shift = $signed(acc_q) >>> bus.imm[4:0];
      if (qnt_shift > INT8_MAX) begin
         qnt_val = INT8_MAX;
      end else if (qnt_shift < INT8_MIN) begin
         qnt_val = INT8_MIN;
      end else begin
         qnt_val = qnt_shift;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= AI_IDLE;
         lane_cnt_q <= '0;
         op_q       <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         work_q     <= '0;
         acc_q      <= '0;
         rd_q       <= '0;
         done_q     <= 1'b0;
         regwrite_q <= 1'b0;
         illegal_q  <= 1'b0;
         result_q   <= '0;
         rd_out_q   <= '0;
      end else begin
         done_q     <= 1'b0;
         regwrite_q <= 1'b0;
         illegal_q  <= 1'b0;
         case (state_q)
            AI_IDLE: begin
               if (accept) begin
                  if (is_dot_op) begin
                     state_q    <= AI_BUSY;
                     op_q       <= bus.ai_opcode;
                     rs1_q      <= bus.rs1_data;
                     rs2_q      <= bus.rs2_data;
                     rd_q       <= bus.rd;
                     work_q     <= '0;
                     lane_cnt_q <= '0;
                  end else begin
                     rd_out_q <= bus.rd;
                     case (bus.ai_opcode)
                        AI_ACC_WR: begin
                           acc_q  <= bus.rs1_data;
                           done_q <= 1'b1;
                        end
                        AI_ACC_RD: begin
                           result_q   <= acc_q;
                           done_q     <= 1'b1;
                           regwrite_q <= 1'b1;
                        end
                        AI_ACC_CLR: begin
                           acc_q      <= '0;
                           result_q   <= '0;
                           done_q     <= 1'b1;
                           regwrite_q <= 1'b1;
                        end
                        AI_QNT: begin
                           result_q   <= qnt_val;
                           done_q     <= 1'b1;
                           regwrite_q <= 1'b1;
                        end
                        default: illegal_q <= 1'b1;
                     endcase
                  end
               end
            end
            AI_BUSY: begin
               if (bus.flush) begin
                  state_q <= AI_IDLE;
               end else begin
                  work_q     <= lane_dot;
                  lane_cnt_q <= lane_cnt_q + 2'd1;
                  // acc only moves when the whole dot product is in.
                  if (lane_cnt_q == LAST_LANE) begin
                     state_q    <= AI_IDLE;
                     done_q     <= 1'b1;
                     regwrite_q <= 1'b1;
                     rd_out_q   <= rd_q;
                     if (op_q == AI_MAC) begin
                        acc_q    <= lane_acc;
                        result_q <= lane_acc;
                     end else begin
                        result_q <= lane_dot;
                     end
                  end
               end
            end
            default: state_q <= AI_IDLE;
         endcase
      end
   end

   assign bus.stall = reset &&
                      (((state_q == AI_IDLE) && bus.in_valid && is_dot_op && !bus.flush) ||
                       ((state_q == AI_BUSY) && (lane_cnt_q != LAST_LANE)));
   assign bus.busy         = (state_q == AI_BUSY);
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.rd_out       = rd_out_q;
   assign bus.regwrite_out = regwrite_q;
   assign bus.illegal      = illegal_q;

endmodule
